// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// Combinational generate/propagate borrow-lookahead subtractor: diff = a - b, bout = borrow out.
module borrow_lookahead_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   bw;

  // Borrow into bit idx as a flat sum of products: some lower bit generates
  // a borrow and every bit between it and idx lets it through (p == 0).
  function automatic logic borrow_into(input logic [N-1:0] gen,
                                       input logic [N-1:0] prop,
                                       input int           idx);
    logic acc;
    logic chain;
    acc   = 1'b0;
    chain = 1'b1;
    for (int j = idx - 1; j >= 0; j--) begin
      acc   = acc | (chain & gen[j]);
      chain = chain & ~prop[j];
    end
    return acc;
  endfunction

  assign p     = a ^ b;
  assign g     = ~a & b;
  assign bw[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi <= N; gi++) begin : g_borrow
      assign bw[gi] = borrow_into(g, p, gi);
    end
  endgenerate

  assign diff = p ^ bw[N-1:0];
  assign bout = bw[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional zero-divisor short-circuit and flag: define DIV_BY_ZERO_DETECT_EN.
module seq_restoring_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dsr_reg, q_work_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   t_val, d_val, r_next;
  logic             borrow, q_bit, last_iter, skip;
  logic             r_top_unused;

  assign t_val     = {r_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign last_iter = (cnt_reg == LAST_ITER);
  // The partial remainder never exceeds the divisor, so its top bit stays clear.
  assign r_top_unused = r_reg[WIDTH];

  borrow_lookahead_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (t_val),
    .b    ({1'b0, dsr_reg}),
    .diff (d_val),
    .bout (borrow)
  );

  assign q_bit  = ~borrow;
  assign r_next = borrow ? t_val : d_val;

`ifdef DIV_BY_ZERO_DETECT_EN
  logic zero_reg, div_by_zero_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      zero_reg        <= (Divisor == '0);
      div_by_zero_reg <= 1'b0;
    end else if (state_reg == CALC && zero_reg) begin
      div_by_zero_reg <= 1'b1;
    end
  end

  assign skip        = zero_reg;
  assign div_by_zero = div_by_zero_reg;
`else
  assign skip        = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter || skip) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      q_work_reg    <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg    <= Dividend;
            dsr_reg    <= Divisor;
            q_work_reg <= '0;
            r_reg      <= '0;
            cnt_reg    <= '0;
          end
        end
        CALC: begin
          if (skip) begin
            // Same answer the full iteration would give for a zero divisor.
            quotient_reg  <= '1;
            remainder_reg <= dvd_reg;
          end else begin
            dvd_reg    <= {dvd_reg[WIDTH-2:0], 1'b0};
            r_reg      <= r_next;
            q_work_reg <= {q_work_reg[WIDTH-2:0], q_bit};
            cnt_reg    <= cnt_reg + CW'(1);
            if (last_iter) begin
              quotient_reg  <= {q_work_reg[WIDTH-2:0], q_bit};
              remainder_reg <= r_next[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Quotient  = quotient_reg;
  assign Remainder = remainder_reg;

endmodule
